// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer.
package trap_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] CAUSE_MTI = 32'h8000_0007;

    typedef enum logic [1:0] {
        TS_IDLE     = 2'd0,
        TS_WAIT_BUS = 2'd1,
        TS_COMMIT   = 2'd2
    } trap_state_t;

    typedef enum logic [1:0] {
        TK_EXC  = 2'd0,
        TK_MRET = 2'd1,
        TK_IRQ  = 2'd2
    } trap_kind_t;

    // Event captured in IDLE and replayed into the CSR file at COMMIT.
    typedef struct packed {
        trap_kind_t      kind;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tval;
    } trap_event_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline / CSR-file side signals of the trap sequencer.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic            exc_valid;
    logic [XLEN-1:0] exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            mret_req;
    logic            int_pc_valid;
    logic [XLEN-1:0] int_pc;
    logic            timer_irq;
    logic            mem_busy;
    logic            mstatus_mie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;

    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_enter;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_val;
    logic            mret_exec;
    logic            bus_timeout;

    // Pipeline and CSR file: raise events, consume redirects.
    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval, mret_req,
        output int_pc_valid, int_pc, timer_irq, mem_busy,
        output mstatus_mie, mie_mtie, mtvec, mepc,
        input  stall, flush, redirect_valid, redirect_pc,
        input  trap_enter, trap_cause, trap_pc, trap_val, mret_exec, bus_timeout
    );

    // Trap sequencer.
    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval, mret_req,
        input  int_pc_valid, int_pc, timer_irq, mem_busy,
        input  mstatus_mie, mie_mtie, mtvec, mepc,
        output stall, flush, redirect_valid, redirect_pc,
        output trap_enter, trap_cause, trap_pc, trap_val, mret_exec, bus_timeout
    );

endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: exception > mret > timer interrupt.
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic       exc_valid,
    input  logic       mret_req,
    input  logic       irq_pend,
    output logic       event_valid,
    output trap_kind_t event_kind
);

    // Pick the highest-priority pending source.
    always_comb begin
        event_valid = exc_valid | mret_req | irq_pend;
        event_kind  = TK_EXC;
        if (exc_valid) begin
            event_kind = TK_EXC;
        end else if (mret_req) begin
            event_kind = TK_MRET;
        end else if (irq_pend) begin
            event_kind = TK_IRQ;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exception / mret / timer irq, waits for the
// data bus to drain, then pulses the CSR update, flush and fetch redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned     BUS_WAIT_MAX = 255,
    parameter logic [XLEN-1:0] MTI_CAUSE    = CAUSE_MTI
) (
    input  logic         clk,
    input  logic         rst,
    trap_ctrl_if.slave   bus
);

    localparam int unsigned   CW         = (BUS_WAIT_MAX == 0) ? 1 : $clog2(BUS_WAIT_MAX + 1);
    localparam logic          TIMEOUT_EN = (BUS_WAIT_MAX != 0);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BUS_WAIT_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT    = '1;

    trap_state_t state_q;
    trap_state_t state_d;
    trap_event_t ev_q;
    logic [CW-1:0] cnt_q;
    logic        timer_irq_q;
    logic        timeout_q;
    logic        force_c;
    logic        irq_pend;
    logic        ev_valid;
    trap_kind_t  ev_kind;
    logic        is_mret;

    assign irq_pend = timer_irq_q & bus.mie_mtie & bus.mstatus_mie & bus.int_pc_valid;
    assign is_mret  = (ev_q.kind == TK_MRET);

    trap_prio_enc u_prio (
        .exc_valid   (bus.exc_valid),
        .mret_req    (bus.mret_req),
        .irq_pend    (irq_pend),
        .event_valid (ev_valid),
        .event_kind  (ev_kind)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; force_c marks a commit forced by the bus-wait limit.
    always_comb begin
        state_d = state_q;
        force_c = 1'b0;
        case (state_q)
            TS_IDLE: begin
                if (ev_valid) begin
                    state_d = bus.mem_busy ? TS_WAIT_BUS : TS_COMMIT;
                end
            end
            TS_WAIT_BUS: begin
                if (!bus.mem_busy) begin
                    state_d = TS_COMMIT;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d = TS_COMMIT;
                    force_c = 1'b1;
                end
            end
            TS_COMMIT: begin
                state_d = TS_IDLE;
            end
            default: begin
                state_d = TS_IDLE;
            end
        endcase
    end

    // Output decode; stall is combinational so the pipeline holds in the event cycle.
    always_comb begin
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.trap_enter     = 1'b0;
        bus.trap_cause     = '0;
        bus.trap_pc        = '0;
        bus.trap_val       = '0;
        bus.mret_exec      = 1'b0;
        bus.bus_timeout    = timeout_q;
        case (state_q)
            TS_IDLE: begin
                bus.stall = ev_valid & ~rst;
            end
            TS_WAIT_BUS: begin
                bus.stall = 1'b1;
            end
            TS_COMMIT: begin
                bus.stall          = 1'b1;
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                if (is_mret) begin
                    bus.mret_exec   = 1'b1;
                    bus.redirect_pc = bus.mepc;
                end else begin
                    bus.trap_enter  = 1'b1;
                    bus.trap_cause  = ev_q.cause;
                    bus.trap_pc     = ev_q.pc;
                    bus.trap_val    = ev_q.tval;
                    bus.redirect_pc = bus.mtvec;
                end
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

    // Timer level sync, event latch, bus-wait counter and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_irq_q <= 1'b0;
            ev_q        <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timer_irq_q <= bus.timer_irq;
            timeout_q   <= force_c;

            if ((state_q == TS_IDLE) && ev_valid) begin
                ev_q.kind <= ev_kind;
                if (ev_kind == TK_EXC) begin
                    ev_q.cause <= bus.exc_cause;
                    ev_q.pc    <= bus.exc_pc;
                    ev_q.tval  <= bus.exc_tval;
                end else if (ev_kind == TK_IRQ) begin
                    ev_q.cause <= MTI_CAUSE;
                    ev_q.pc    <= bus.int_pc;
                    ev_q.tval  <= '0;
                end
            end

            if (state_q == TS_WAIT_BUS) begin
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule
